// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the 4-bit-opcode accumulator CPU.
//   - opcode constants, shared by the fetch unit and the control decoder
//   - instruction-field and address widths
//   - fetch/sequencing FSM state encoding
//   - small helpers used by the fetch unit
// ---------------------------------------------------------------------------
package cpu_pkg;

  localparam int OPC_W   = 4;
  localparam int IMM_W   = 4;
  localparam int PC_W    = 8;
  localparam int CNT_W   = 16;
  localparam int INSTR_W = OPC_W + IMM_W;

  typedef enum logic [OPC_W-1:0] {
    ADD = 4'd0,
    SUB = 4'd1,
    LDA = 4'd2,
    STA = 4'd3,
    LDB = 4'd4,
    STB = 4'd5,
    LDC = 4'd6,
    JMP = 4'd7
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HALT   = 3'd4
  } state_e;

  // Defined opcodes occupy 0..7, so the top opcode bit alone marks an
  // undefined instruction.
  function automatic logic opcode_defined(input logic [OPC_W-1:0] op);
    return (op[OPC_W-1] == 1'b0);
  endfunction

endpackage

// File: rtl/unidade_busca.sv
// ---------------------------------------------------------------------------
// unidade_busca
// Instruction fetch and sequencing unit. Holds the program counter, fetches
// instruction words over a req/ack handshake, presents one opcode/immediate
// at a time to the decoder, resolves JMP (taken when A == 0), counts retired
// instructions and halts on undefined opcodes.
//
// Ports
//   clk, rst      clock, asynchronous active-high reset
//   start         leave IDLE and fetch from address 0 (ignored elsewhere)
//   imem_req      fetch request, held until imem_ack
//   imem_addr     fetch address (= pc)
//   imem_ack      instruction word valid on imem_data this cycle
//   imem_data     instruction word {opcode, imm}
//   opcode, imm   instruction register fields
//   instr_valid   one-cycle pulse in DECODE
//   branch        decoder Branch output for the current opcode
//   zero          accumulator A == 0
//   exec_done     datapath finished the current instruction
//   pc            program counter
//   halted        undefined opcode encountered (sticky)
//   retired       saturating count of completed instructions
// ---------------------------------------------------------------------------
module unidade_busca
  import cpu_pkg::*;
#(
  parameter int PC_W  = cpu_pkg::PC_W,
  parameter int IMM_W = cpu_pkg::IMM_W,
  parameter int CNT_W = cpu_pkg::CNT_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic                   imem_req,
  output logic [PC_W-1:0]        imem_addr,
  input  logic                   imem_ack,
  input  logic [OPC_W+IMM_W-1:0] imem_data,
  output logic [OPC_W-1:0]       opcode,
  output logic [IMM_W-1:0]       imm,
  output logic                   instr_valid,
  input  logic                   branch,
  input  logic                   zero,
  input  logic                   exec_done,
  output logic [PC_W-1:0]        pc,
  output logic                   halted,
  output logic [CNT_W-1:0]       retired
);

  state_e             state_r;
  state_e             state_s;
  logic [PC_W-1:0]    pc_r;
  logic [OPC_W-1:0]   opcode_r;
  logic [IMM_W-1:0]   imm_r;
  logic               taken_r;
  logic [CNT_W-1:0]   retired_r;
  logic               imem_req_r;
  logic               instr_valid_r;
  logic               halted_r;

  // Next-state logic of the fetch/decode/execute sequencer.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s = ST_FETCH;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (imem_ack) begin
          state_s = ST_DECODE;
        end else begin
          state_s = ST_FETCH;
        end
      end
      ST_DECODE: begin
        if (opcode_defined(opcode_r)) begin
          state_s = ST_EXEC;
        end else begin
          state_s = ST_HALT;
        end
      end
      ST_EXEC: begin
        if (exec_done) begin
          state_s = ST_FETCH;
        end else begin
          state_s = ST_EXEC;
        end
      end
      ST_HALT: state_s = ST_HALT;
      default: state_s = ST_IDLE;
    endcase
  end

  // State register plus state-decoded flags, registered from the next state
  // so they are glitch-free and clear asynchronously with rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      imem_req_r    <= 1'b0;
      instr_valid_r <= 1'b0;
      halted_r      <= 1'b0;
    end else begin
      state_r       <= state_s;
      imem_req_r    <= (state_s == ST_FETCH);
      instr_valid_r <= (state_s == ST_DECODE);
      halted_r      <= (state_s == ST_HALT);
    end
  end

  // Instruction register: loaded only on an acknowledged fetch, so spurious
  // acks outside FETCH never disturb the presented opcode/imm.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opcode_r <= {OPC_W{1'b0}};
      imm_r    <= {IMM_W{1'b0}};
    end else if ((state_r == ST_FETCH) && imem_ack) begin
      {opcode_r, imm_r} <= imem_data;
    end else begin
      opcode_r <= opcode_r;
      imm_r    <= imm_r;
    end
  end

  // Branch decision is captured in DECODE; zero may change during EXEC as
  // the datapath works, and must not affect the already-resolved jump.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      taken_r <= 1'b0;
    end else if (state_r == ST_DECODE) begin
      taken_r <= branch & zero;
    end else begin
      taken_r <= taken_r;
    end
  end

  // Program counter and retired counter advance together when an
  // instruction completes. pc wraps naturally; retired saturates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_r      <= {PC_W{1'b0}};
      retired_r <= {CNT_W{1'b0}};
    end else if ((state_r == ST_EXEC) && exec_done) begin
      if (taken_r) begin
        pc_r <= PC_W'(imm_r);
      end else begin
        pc_r <= pc_r + {{(PC_W-1){1'b0}}, 1'b1};
      end
      if (retired_r != {CNT_W{1'b1}}) begin
        retired_r <= retired_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        retired_r <= retired_r;
      end
    end else begin
      pc_r      <= pc_r;
      retired_r <= retired_r;
    end
  end

  assign imem_req    = imem_req_r;
  assign imem_addr   = pc_r;
  assign opcode      = opcode_r;
  assign imm         = imm_r;
  assign instr_valid = instr_valid_r;
  assign pc          = pc_r;
  assign halted      = halted_r;
  assign retired     = retired_r;

endmodule
